// File: rtl/scroll_controller.sv
// scroll_controller
//
// Owns the scroll origin (first_char) of the 80x24 character buffer. It also
// issues the buffer writes that blank rows for scrolling and the whole buffer
// for clearing. A combinational translator maps a visible row index to the
// buffer address of that row's column 0, taking the circular origin into
// account.
//
// Optional feature macro: SCROLL_DOWN_EN
//   Defined:   the scroll_down port and the reverse-scroll path exist.
//   Undefined: only clear and scroll_up exist.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   clear          in   request: blank the whole buffer and home the origin
//   scroll_up      in   request: advance origin one row, blank new bottom row
//   scroll_down    in   request: retreat origin one row, blank new top row
//                       (present only with SCROLL_DOWN_EN)
//   busy           out  fill in progress; requests are ignored while high
//   first_char     out  buffer address of the top-left visible character
//   buffer_address out  char buffer write address
//   buffer_data    out  char buffer write data (always FILL_CHAR)
//   buffer_write   out  char buffer write enable
//   row            in   row index to translate
//   row_address    out  buffer address of column 0 of row

module scroll_controller #(
  parameter int              ROWS          = 24,
  parameter int              COLS          = 80,
  parameter int              ROW_BITS      = 5,
  parameter int              ADDR_BITS     = 11,
  parameter int              PAST_LAST_ROW = ROWS * COLS,
  parameter logic [7:0]      FILL_CHAR     = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 scroll_up,
`ifdef SCROLL_DOWN_EN
  input  logic                 scroll_down,
`endif
  output logic                 busy,
  output logic [ADDR_BITS-1:0] first_char,
  output logic [ADDR_BITS-1:0] buffer_address,
  output logic [7:0]           buffer_data,
  output logic                 buffer_write,
  input  logic [ROW_BITS-1:0]  row,
  output logic [ADDR_BITS-1:0] row_address
);

  localparam int                   AW1     = ADDR_BITS + 1;
  localparam logic [ADDR_BITS-1:0] COLS_A  = ADDR_BITS'(COLS);
  localparam logic [ADDR_BITS-1:0] PAST_A  = ADDR_BITS'(PAST_LAST_ROW);
  localparam logic [ADDR_BITS-1:0] LAST_A  = ADDR_BITS'(PAST_LAST_ROW - 1);
  localparam logic [ADDR_BITS-1:0] BOTTOM_A = ADDR_BITS'(PAST_LAST_ROW - COLS);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t                 state;
  logic [ADDR_BITS-1:0]   fill_end;
  logic [ADDR_BITS-1:0]   up_origin;

  assign buffer_data = FILL_CHAR;

  // Origin after a scroll up; wraps to 0 once it would leave the buffer.
  always_comb begin
    up_origin = first_char + COLS_A;
    if (up_origin == PAST_A) begin
      up_origin = '0;
    end
  end

`ifdef SCROLL_DOWN_EN
  logic [ADDR_BITS-1:0] down_origin;

  // Origin after a scroll down; from the top it wraps to the last row start.
  always_comb begin
    if (first_char == '0) begin
      down_origin = BOTTOM_A;
    end else begin
      down_origin = first_char - COLS_A;
    end
  end
`endif

  // buffer_address doubles as the fill pointer; fill_end is the last
  // address to write, so the fill stops right after presenting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      buffer_write   <= 1'b0;
      buffer_address <= '0;
      first_char     <= '0;
      fill_end       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            first_char     <= '0;
            buffer_address <= '0;
            fill_end       <= LAST_A;
            busy           <= 1'b1;
            buffer_write   <= 1'b1;
            state          <= FILL;
          end else if (scroll_up) begin
            first_char     <= up_origin;
            buffer_address <= first_char;
            fill_end       <= first_char + COLS_A - 1'b1;
            busy           <= 1'b1;
            buffer_write   <= 1'b1;
            state          <= FILL;
          end
`ifdef SCROLL_DOWN_EN
          else if (scroll_down) begin
            first_char     <= down_origin;
            buffer_address <= down_origin;
            fill_end       <= down_origin + COLS_A - 1'b1;
            busy           <= 1'b1;
            buffer_write   <= 1'b1;
            state          <= FILL;
          end
`endif
        end
        FILL: begin
          if (buffer_address == fill_end) begin
            busy         <= 1'b0;
            buffer_write <= 1'b0;
            state        <= IDLE;
          end else begin
            buffer_address <= buffer_address + 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          buffer_write <= 1'b0;
        end
      endcase
    end
  end

  logic [AW1-1:0] row_sum;

  // The sum is one bit wider so an origin near the bottom plus a large row
  // offset cannot overflow before the single wrap subtraction.
  always_comb begin
    row_sum = {1'b0, first_char} + AW1'(row) * AW1'(COLS);
    if (row_sum >= AW1'(PAST_LAST_ROW)) begin
      row_sum = row_sum - AW1'(PAST_LAST_ROW);
    end
    if (row >= ROW_BITS'(ROWS)) begin
      row_address = first_char;
    end else begin
      row_address = row_sum[ADDR_BITS-1:0];
    end
  end

endmodule

// File: tb/tb_scroll_controller.sv
// tb_scroll_controller
//
// Self-checking bench for scroll_controller. A behavioural model tracks the
// scroll origin with modular arithmetic and predicts the fill range of each
// request; every cycle of every fill is compared against it. Randomized
// request mixes, dropped mid-fill requests and row translations are added on
// top of the directed scenarios.
//
// Build with SCROLL_DOWN_EN defined to exercise the reverse-scroll path.

module tb_scroll_controller;

  localparam int ROWS = 24;
  localparam int COLS = 80;
  localparam int PAST = ROWS * COLS;

`ifdef SCROLL_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        clear;
  logic        scroll_up;
`ifdef SCROLL_DOWN_EN
  logic        scroll_down;
`endif
  logic        busy;
  logic [10:0] first_char;
  logic [10:0] buffer_address;
  logic [7:0]  buffer_data;
  logic        buffer_write;
  logic [4:0]  row_sel;
  logic [10:0] row_address;

  int tests_run;
  int tests_failed;
  int origin;

  scroll_controller dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .scroll_up      (scroll_up),
`ifdef SCROLL_DOWN_EN
    .scroll_down    (scroll_down),
`endif
    .busy           (busy),
    .first_char     (first_char),
    .buffer_address (buffer_address),
    .buffer_data    (buffer_data),
    .buffer_write   (buffer_write),
    .row            (row_sel),
    .row_address    (row_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveRequests(input bit c, input bit u, input bit d);
    clear     = c;
    scroll_up = u;
`ifdef SCROLL_DOWN_EN
    scroll_down = d;
`endif
    if (!DOWN_EN && d) begin
      scroll_up = u;
    end
  endtask

  task automatic checkRow(input int r);
    int expected;
    row_sel = 5'(r);
    #1;
    if (r < ROWS) expected = (origin + r * COLS) % PAST;
    else          expected = origin;
    checkOutput("row_address", int'(row_address), expected);
  endtask

  // Issues one request vector and checks the whole resulting fill. drop_at
  // selects a fill cycle in which a random request is pulsed (it must be
  // ignored); -1 disables it.
  task automatic applyStimulus(input bit c, input bit u, input bit d, input int drop_at);
    int  start;
    int  len;
    int  new_origin;
    bit  d_eff;
    d_eff      = DOWN_EN && d;
    start      = 0;
    len        = 0;
    new_origin = origin;
    if (c) begin
      new_origin = 0;
      start      = 0;
      len        = PAST;
    end else if (u) begin
      start      = origin;
      new_origin = (origin + COLS) % PAST;
      len        = COLS;
    end else if (d_eff) begin
      new_origin = (origin + PAST - COLS) % PAST;
      start      = new_origin;
      len        = COLS;
    end
    driveRequests(c, u, d);
    tick();
    driveRequests(1'b0, 1'b0, 1'b0);
    origin = new_origin;
    for (int k = 0; k < len; k++) begin
      checkOutput("busy_during_fill", int'(busy), 1);
      checkOutput("write_during_fill", int'(buffer_write), 1);
      checkOutput("fill_address", int'(buffer_address), start + k);
      checkOutput("first_char_during_fill", int'(first_char), origin);
      checkOutput("buffer_data", int'(buffer_data), 32);
      if (k == drop_at) begin
        driveRequests(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
      end
      tick();
      driveRequests(1'b0, 1'b0, 1'b0);
    end
    checkOutput("busy_after_fill", int'(busy), 0);
    checkOutput("write_after_fill", int'(buffer_write), 0);
    checkOutput("first_char_after_fill", int'(first_char), origin);
  endtask

  initial begin
    bit c;
    bit u;
    bit d;
    int drop;
    tests_run    = 0;
    tests_failed = 0;
    origin       = 0;
    row_sel      = '0;
    reset        = 1'b1;
    driveRequests(1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_write", int'(buffer_write), 0);
    checkOutput("reset_address", int'(buffer_address), 0);
    checkOutput("reset_first_char", int'(first_char), 0);
    checkOutput("reset_data", int'(buffer_data), 32);
    reset = 1'b0;
    tick();

    // Full clear after reset.
    applyStimulus(1'b1, 1'b0, 1'b0, -1);

    // First scroll up from origin 0, then bottom row maps back to 0.
    applyStimulus(1'b0, 1'b1, 1'b0, -1);
    checkOutput("origin_after_first_up", int'(first_char), 80);
    checkRow(23);

    // Walk the origin to the last row start, then wrap.
    while (origin != PAST - COLS) applyStimulus(1'b0, 1'b1, 1'b0, -1);
    applyStimulus(1'b0, 1'b1, 1'b0, -1);
    checkOutput("origin_after_wrap", int'(first_char), 0);
    checkRow(1);

    // Reverse scroll from the top wraps to the last row.
    if (DOWN_EN) begin
      applyStimulus(1'b0, 1'b0, 1'b1, -1);
      checkOutput("origin_after_down_wrap", int'(first_char), 1840);
      checkRow(0);
    end

    // Coinciding clear and scroll_up, plus a scroll_up while busy.
    applyStimulus(1'b1, 1'b1, 1'b0, 9);
    checkOutput("origin_after_priority", int'(first_char), 0);

    // Randomized request mix.
    for (int i = 0; i < 40; i++) begin
      c = ($urandom_range(0, 19) == 0);
      u = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, COLS - 2)) : -1;
      applyStimulus(c, u, d, drop);
      checkRow(int'($urandom_range(0, 31)));
      checkRow(int'($urandom_range(0, 23)));
      repeat ($urandom_range(0, 3)) begin
        tick();
        checkOutput("idle_write", int'(buffer_write), 0);
      end
    end

    // Reset five cycles into a scroll fill.
    driveRequests(1'b0, 1'b1, 1'b0);
    tick();
    driveRequests(1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    checkOutput("write_before_reset", int'(buffer_write), 1);
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    origin = 0;
    checkOutput("midfill_reset_busy", int'(busy), 0);
    checkOutput("midfill_reset_write", int'(buffer_write), 0);
    checkOutput("midfill_reset_first_char", int'(first_char), 0);
    repeat (10) begin
      tick();
      checkOutput("no_write_after_reset", int'(buffer_write), 0);
    end
    checkRow(5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
